// File: rtl/input_conditioner.sv
`timescale 1ns/1ps
// input_conditioner: 2-flop synchronizers plus a tick-paced saturating debouncer for switches and buttons.
// Define INPUT_COND_EDGE_EN to build the registered btn_rise/btn_fall pulses (tied to 0 otherwise).
module input_conditioner #(
   parameter int SW_W       = 16,
   parameter int BTN_W      = 5,
   parameter int TICK_DIV   = 50000,
   parameter int DB_SAMPLES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [SW_W-1:0]  sw,
   input  logic [BTN_W-1:0] btn,
   output logic [SW_W-1:0]  sw_db,
   output logic [BTN_W-1:0] btn_db,
   output logic [BTN_W-1:0] btn_rise,
   output logic [BTN_W-1:0] btn_fall,
   output logic             tick
);
   localparam int ALL_W = SW_W + BTN_W;
   localparam int DIV_W = $clog2(TICK_DIV);
   localparam int CNT_W = (DB_SAMPLES > 1) ? $clog2(DB_SAMPLES) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_SAMPLES - 1);

   logic [ALL_W-1:0] s1, s2, stable, flip;
   logic [DIV_W-1:0] div_cnt;
   logic [CNT_W-1:0] cnt [ALL_W];

   // Switches occupy the low bits, buttons the high bits, of every per-bit vector.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         // NOTE: non-blocking so s2 takes the old s1, giving two real flop stages.
         s1 <= {btn, sw};
         s2 <= s1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         div_cnt <= '0;
      else if (div_cnt == DIV_LAST)
         div_cnt <= '0;
      else
         div_cnt <= div_cnt + 1'b1;
   end

   assign tick = (div_cnt == DIV_LAST);

   always_comb begin
      // NOTE: default assignment first so no path leaves flip unassigned and infers a latch.
      flip = '0;
      for (int i = 0; i < ALL_W; i++)
         flip[i] = tick && (s2[i] != stable[i]) && (cnt[i] == CNT_LAST);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stable <= '0;
         // NOTE: cnt is a bank of flops, not a RAM, so every entry is cleared to discard partial counts.
         for (int i = 0; i < ALL_W; i++)
            cnt[i] <= '0;
      end else if (tick) begin
         stable <= stable ^ flip;
         for (int i = 0; i < ALL_W; i++) begin
            if ((s2[i] == stable[i]) || flip[i])
               cnt[i] <= '0;
            else
               cnt[i] <= cnt[i] + 1'b1;
         end
      end
   end

   assign sw_db  = stable[SW_W-1:0];
   assign btn_db = stable[ALL_W-1:SW_W];

`ifdef INPUT_COND_EDGE_EN
   logic [BTN_W-1:0] btn_flip, btn_new;

   // On a flip the new level is s2, so the pulse lands on the same edge as btn_db.
   assign btn_flip = flip[ALL_W-1:SW_W];
   assign btn_new  = s2[ALL_W-1:SW_W];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         btn_rise <= '0;
         btn_fall <= '0;
      end else begin
         btn_rise <= btn_flip & btn_new;
         btn_fall <= btn_flip & ~btn_new;
      end
   end
`else
   assign btn_rise = '0;
   assign btn_fall = '0;
`endif

endmodule
